timer_display: RTL

Consumer of the countdown timer's BCD digits (`min`, `sec1`, `sec2`). It drives a 4-digit multiplexed common-anode 7-segment display with a tear-free per-frame snapshot and shows a status glyph for paused or expired. When the countdown reaches 0:00 it blinks the time digits and raises an expiry flag plus a one-cycle pulse for the game FSM. It sits between the timer and the board display pins.

---
 rtl/timer_display.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/timer_display.sv
// Multiplexed 4-digit 7-segment driver for the countdown timer: per-frame
// snapshot, status glyph, expiry detection and blinking of the time digits.
module timer_display #(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLINK_SCANS = 125,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] min,
    input  logic [3:0] sec1,
    input  logic [3:0] sec2,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       expired,
    output logic       expired_pulse
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned FRM_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;
    localparam logic        POL   = (ACTIVE_LOW != 0);

    localparam logic [6:0] GLYPH_E     = 7'b1111001;
    localparam logic [6:0] GLYPH_P     = 7'b1110011;
    localparam logic [6:0] GLYPH_DASH  = 7'b1000000;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

    // Active-high {g..a} pattern for a BCD digit; out-of-range shows '-'.
    function automatic logic [6:0] bcd_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b0111111;
            4'd1:    g = 7'b0000110;
            4'd2:    g = 7'b1011011;
            4'd3:    g = 7'b1001111;
            4'd4:    g = 7'b1100110;
            4'd5:    g = 7'b1101101;
            4'd6:    g = 7'b1111101;
            4'd7:    g = 7'b0000111;
            4'd8:    g = 7'b1111111;
            4'd9:    g = 7'b1101111;
            default: g = GLYPH_DASH;
        endcase
        return g;
    endfunction

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       snap_min_q, snap_min_d;
    logic [3:0]       snap_sec1_q, snap_sec1_d;
    logic [3:0]       snap_sec2_q, snap_sec2_d;
    logic             snap_start_q, snap_start_d;
    logic             expired_q, expired_d;
    logic             exp_dly_q, exp_dly_d;
    logic             pulse_q, pulse_d;
    logic             blink_on_q, blink_on_d;
    logic [FRM_W-1:0] frame_q, frame_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       an_q, an_d;

    logic             tc;
    logic             cap;
    logic             in_zero;
    logic             rise;
    logic             blank_time;
    logic [6:0]       seg_hi;
    logic             dp_hi;

    // Next-state: scan prescaler, frame snapshot, expiry and blink tracking.
    always_comb begin
        div_cnt_d    = div_cnt_q;
        idx_d        = idx_q;
        snap_min_d   = snap_min_q;
        snap_sec1_d  = snap_sec1_q;
        snap_sec2_d  = snap_sec2_q;
        snap_start_d = snap_start_q;
        expired_d    = expired_q;
        blink_on_d   = blink_on_q;
        frame_d      = frame_q;
        rise         = 1'b0;

        tc      = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
        cap     = tc && (idx_q == 2'd0);
        in_zero = (min == 4'd0) && (sec1 == 4'd0) && (sec2 == 4'd0);

        div_cnt_d = tc ? '0 : div_cnt_q + DIV_W'(1);
        if (tc) begin
            idx_d = idx_q - 2'd1;
        end

        if (cap) begin
            snap_min_d   = min;
            snap_sec1_d  = sec1;
            snap_sec2_d  = sec2;
            snap_start_d = start;
            if (!in_zero) begin
                expired_d = 1'b0;
            end else if (start) begin
                expired_d = 1'b1;
            end
            rise = expired_d && !expired_q;
            if (rise) begin
                frame_d    = '0;
                blink_on_d = 1'b1;
            end else if (frame_q == FRM_W'(BLINK_SCANS - 1)) begin
                frame_d    = '0;
                blink_on_d = !blink_on_q;
            end else begin
                frame_d = frame_q + FRM_W'(1);
            end
        end
        if (!expired_d) begin
            blink_on_d = 1'b1;
        end

        exp_dly_d = expired_q;
        pulse_d   = expired_q && !exp_dly_q;
    end

    // Display decode from the current digit index and snapshot.
    always_comb begin
        seg_hi     = GLYPH_BLANK;
        dp_hi      = 1'b0;
        blank_time = expired_q && !blink_on_q;
        case (idx_q)
            2'd3: begin
                seg_hi = bcd_glyph(snap_min_q);
                dp_hi  = 1'b1;
            end
            2'd2: seg_hi = bcd_glyph(snap_sec1_q);
            2'd1: seg_hi = bcd_glyph(snap_sec2_q);
            default: begin
                if (expired_q) begin
                    seg_hi = GLYPH_E;
                end else if (!snap_start_q) begin
                    seg_hi = GLYPH_P;
                end
            end
        endcase
        if (blank_time && (idx_q != 2'd0)) begin
            seg_hi = GLYPH_BLANK;
            dp_hi  = 1'b0;
        end
        seg_d = seg_hi ^ {7{POL}};
        dp_d  = dp_hi ^ POL;
        an_d  = (4'b0001 << idx_q) ^ {4{POL}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            idx_q        <= 2'd3;
            snap_min_q   <= 4'd2;
            snap_sec1_q  <= 4'd0;
            snap_sec2_q  <= 4'd0;
            snap_start_q <= 1'b0;
            expired_q    <= 1'b0;
            exp_dly_q    <= 1'b0;
            pulse_q      <= 1'b0;
            blink_on_q   <= 1'b1;
            frame_q      <= '0;
            seg_q        <= {7{POL}};
            dp_q         <= POL;
            an_q         <= {4{POL}};
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            snap_min_q   <= snap_min_d;
            snap_sec1_q  <= snap_sec1_d;
            snap_sec2_q  <= snap_sec2_d;
            snap_start_q <= snap_start_d;
            expired_q    <= expired_d;
            exp_dly_q    <= exp_dly_d;
            pulse_q      <= pulse_d;
            blink_on_q   <= blink_on_d;
            frame_q      <= frame_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign seg           = seg_q;
    assign dp            = dp_q;
    assign an            = an_q;
    assign expired       = expired_q;
    assign expired_pulse = pulse_q;

endmodule
